// File: rtl/ddram_arb_pkg.sv
// Shared constants for the two-master DDRAM arbiter: bus widths and FSM state encodings.
package ddram_arb_pkg;

  localparam int unsigned DDR_ADDR_W = 29;
  localparam int unsigned DDR_DATA_W = 64;
  localparam int unsigned DDR_BE_W   = 8;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StWrite = 2'd1;
  localparam logic [1:0] StRead  = 2'd2;

endpackage

// File: rtl/ddram_arbiter.sv
// Burst-locked two-master arbiter for the MiSTer DDRAM Avalon-MM port; port 0 has priority,
// port 1 is forced after STARVE_MAX starved grants. Define DDRAM_ARBITER_STATS_EN for counters.
module ddram_arbiter
  import ddram_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned BURST_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,

  output logic                  m0_busy,
  input  logic [BURST_W-1:0]    m0_burstcnt,
  input  logic [DDR_ADDR_W-1:0] m0_addr,
  input  logic [DDR_DATA_W-1:0] m0_din,
  input  logic [DDR_BE_W-1:0]   m0_be,
  input  logic                  m0_we,
  input  logic                  m0_rd,
  output logic [DDR_DATA_W-1:0] m0_dout,
  output logic                  m0_dout_ready,

  output logic                  m1_busy,
  input  logic [BURST_W-1:0]    m1_burstcnt,
  input  logic [DDR_ADDR_W-1:0] m1_addr,
  input  logic [DDR_DATA_W-1:0] m1_din,
  input  logic [DDR_BE_W-1:0]   m1_be,
  input  logic                  m1_we,
  input  logic                  m1_rd,
  output logic [DDR_DATA_W-1:0] m1_dout,
  output logic                  m1_dout_ready,

  input  logic                  DDRAM_BUSY,
  output logic [BURST_W-1:0]    DDRAM_BURSTCNT,
  output logic [DDR_ADDR_W-1:0] DDRAM_ADDR,
  output logic [DDR_DATA_W-1:0] DDRAM_DIN,
  output logic [DDR_BE_W-1:0]   DDRAM_BE,
  output logic                  DDRAM_WE,
  output logic                  DDRAM_RD,
  input  logic [DDR_DATA_W-1:0] DDRAM_DOUT,
  input  logic                  DDRAM_DOUT_READY
`ifdef DDRAM_ARBITER_STATS_EN
  ,
  output logic [15:0]           stat_grant0,
  output logic [15:0]           stat_grant1,
  output logic [15:0]           stat_forced
`endif
);

  localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);

  logic [1:0]         state_q, state_d;
  logic               owner_q, owner_d;
  logic [BURST_W-1:0] beat_q, beat_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               rd_acc_q, rd_acc_d;
  logic [StarveW-1:0] starve_q, starve_d;

  logic [1:0]            req, we_v, rd_v, busy_v, rdy_v;
  logic [BURST_W-1:0]    bc_v   [2];
  logic [DDR_ADDR_W-1:0] addr_v [2];
  logic [DDR_DATA_W-1:0] din_v  [2];
  logic [DDR_BE_W-1:0]   be_v   [2];

  assign we_v      = {m1_we, m0_we};
  assign rd_v      = {m1_rd, m0_rd};
  assign bc_v[0]   = m0_burstcnt;
  assign bc_v[1]   = m1_burstcnt;
  assign addr_v[0] = m0_addr;
  assign addr_v[1] = m1_addr;
  assign din_v[0]  = m0_din;
  assign din_v[1]  = m1_din;
  assign be_v[0]   = m0_be;
  assign be_v[1]   = m1_be;

  logic               active, own_busy, grant1, starved;
  logic [BURST_W-1:0] sel_bc, tgt;

  assign active   = (state_q != StIdle);
  assign sel_bc   = (bc_v[owner_q] == '0) ? BURST_W'(1) : bc_v[owner_q];
  // Once a read command is accepted the owner must not issue another until data returns.
  assign own_busy = (state_q == StRead && rd_acc_q) ? 1'b1 : DDRAM_BUSY;
  assign starved  = (starve_q == StarveW'(STARVE_MAX));
  assign grant1   = req[1] & (~req[0] | starved);

  for (genvar p = 0; p < 2; p++) begin : g_port
    assign req[p]    = we_v[p] | rd_v[p];
    assign busy_v[p] = (active && owner_q == 1'(p)) ? own_busy : 1'b1;
    assign rdy_v[p]  = (state_q == StRead && rd_acc_q && owner_q == 1'(p)) ? DDRAM_DOUT_READY
                                                                           : 1'b0;
  end

  assign {m1_busy, m0_busy}             = busy_v;
  assign {m1_dout_ready, m0_dout_ready} = rdy_v;
  assign m0_dout = DDRAM_DOUT;
  assign m1_dout = DDRAM_DOUT;

  assign DDRAM_WE       = (state_q == StWrite) & we_v[owner_q];
  assign DDRAM_RD       = (state_q == StRead) & ~rd_acc_q & rd_v[owner_q];
  assign DDRAM_BURSTCNT = active ? sel_bc : '0;
  assign DDRAM_ADDR     = active ? addr_v[owner_q] : '0;
  assign DDRAM_DIN      = active ? din_v[owner_q] : '0;
  assign DDRAM_BE       = active ? be_v[owner_q] : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    burst_d  = burst_q;
    rd_acc_d = rd_acc_q;
    starve_d = starve_q;
    tgt      = (beat_q == '0) ? sel_bc : burst_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d  = grant1;
          state_d  = we_v[grant1] ? StWrite : StRead;
          beat_d   = '0;
          rd_acc_d = 1'b0;
          if (!grant1 && req[1]) begin
            starve_d = starved ? starve_q : starve_q + 1'b1;
          end else begin
            starve_d = '0;
          end
        end
      end
      StWrite: begin
        if (DDRAM_WE && !DDRAM_BUSY) begin
          if (beat_q == '0) burst_d = sel_bc;
          if (beat_q + 1'b1 == tgt) begin
            state_d = StIdle;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      StRead: begin
        if (!rd_acc_q) begin
          if (DDRAM_RD && !DDRAM_BUSY) begin
            rd_acc_d = 1'b1;
            burst_d  = sel_bc;
          end
        end else if (DDRAM_DOUT_READY) begin
          if (beat_q + 1'b1 == burst_q) begin
            state_d  = StIdle;
            beat_d   = '0;
            rd_acc_d = 1'b0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      beat_q   <= '0;
      burst_q  <= '0;
      rd_acc_q <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
      burst_q  <= burst_d;
      rd_acc_q <= rd_acc_d;
      starve_q <= starve_d;
    end
  end

`ifdef DDRAM_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_grant0 <= '0;
      stat_grant1 <= '0;
      stat_forced <= '0;
    end else if (state_q == StIdle && |req) begin
      if (grant1) begin
        stat_grant1 <= stat_grant1 + 16'd1;
        if (req[0]) stat_forced <= stat_forced + 16'd1;
      end else begin
        stat_grant0 <= stat_grant0 + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ddram_arbiter.sv
// Scoreboard bench for ddram_arbiter: directed bursts push expected beats, a monitor checks them.
module tb_ddram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_busy, m1_busy, m0_dout_ready, m1_dout_ready;
  logic [7:0]  m0_burstcnt, m1_burstcnt, m0_be, m1_be;
  logic [28:0] m0_addr, m1_addr;
  logic [63:0] m0_din, m1_din, m0_dout, m1_dout;
  logic        m0_we, m0_rd, m1_we, m1_rd;
  logic        DDRAM_BUSY, DDRAM_WE, DDRAM_RD, DDRAM_DOUT_READY;
  logic [7:0]  DDRAM_BURSTCNT, DDRAM_BE;
  logic [28:0] DDRAM_ADDR;
  logic [63:0] DDRAM_DIN, DDRAM_DOUT;
`ifdef DDRAM_ARBITER_STATS_EN
  logic [15:0] stat_grant0, stat_grant1, stat_forced;
`endif

  ddram_arbiter #(.STARVE_MAX(8), .BURST_W(8)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_busy          (m0_busy),
    .m0_burstcnt      (m0_burstcnt),
    .m0_addr          (m0_addr),
    .m0_din           (m0_din),
    .m0_be            (m0_be),
    .m0_we            (m0_we),
    .m0_rd            (m0_rd),
    .m0_dout          (m0_dout),
    .m0_dout_ready    (m0_dout_ready),
    .m1_busy          (m1_busy),
    .m1_burstcnt      (m1_burstcnt),
    .m1_addr          (m1_addr),
    .m1_din           (m1_din),
    .m1_be            (m1_be),
    .m1_we            (m1_we),
    .m1_rd            (m1_rd),
    .m1_dout          (m1_dout),
    .m1_dout_ready    (m1_dout_ready),
`ifdef DDRAM_ARBITER_STATS_EN
    .stat_grant0      (stat_grant0),
    .stat_grant1      (stat_grant1),
    .stat_forced      (stat_forced),
`endif
    .DDRAM_BUSY       (DDRAM_BUSY),
    .DDRAM_BURSTCNT   (DDRAM_BURSTCNT),
    .DDRAM_ADDR       (DDRAM_ADDR),
    .DDRAM_DIN        (DDRAM_DIN),
    .DDRAM_BE         (DDRAM_BE),
    .DDRAM_WE         (DDRAM_WE),
    .DDRAM_RD         (DDRAM_RD),
    .DDRAM_DOUT       (DDRAM_DOUT),
    .DDRAM_DOUT_READY (DDRAM_DOUT_READY)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [28:0] addr;
    logic [7:0]  bc;
    logic [63:0] data;
  } beat_t;

  beat_t wq[$];
  beat_t cq[$];
  beat_t rq[$];
  beat_t mw, mc, mr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_beats = 0;
  int last_cyc [2];
  int rdn;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  function automatic logic [63:0] wdata(input int p, input logic [28:0] a, input int i);
    return {4'(p), 3'b000, a, 8'h00, 20'(i)};
  endfunction

  task automatic exp_wr(input int p, input logic [28:0] a, input logic [7:0] bc, input int i);
    wq.push_back('{port: p, addr: a, bc: bc, data: wdata(p, a, i)});
  endtask

  task automatic drv(input int p, input logic we, input logic rd, input logic [28:0] a,
                     input logic [7:0] bc, input logic [63:0] d);
    if (p == 0) begin
      m0_we = we; m0_rd = rd; m0_addr = a; m0_burstcnt = bc; m0_din = d; m0_be = 8'hff;
    end else begin
      m1_we = we; m1_rd = rd; m1_addr = a; m1_burstcnt = bc; m1_din = d; m1_be = 8'hff;
    end
  endtask

  // Call at posedge+1; returns at posedge+1 after the last accepted beat (or on reset).
  task automatic master_write(input int p, input logic [28:0] a, input logic [7:0] bc,
                              input int nb);
    int  i = 0;
    int  t = 0;
    logic acc;
    drv(p, 1'b1, 1'b0, a, bc, wdata(p, a, 0));
    while (i < nb && reset_n) begin
      @(negedge clk);
      acc = (p == 0) ? !m0_busy : !m1_busy;
      @(posedge clk);
      #1;
      if (acc) begin
        i++;
        drv(p, 1'b1, 1'b0, a, bc, wdata(p, a, i));
      end
      t++;
      if (t > 300) begin
        timeout_fail("master_write");
        break;
      end
    end
    drv(p, 1'b0, 1'b0, 29'h0, 8'h0, 64'h0);
  endtask

  task automatic master_read(input int p, input logic [28:0] a, input logic [7:0] bc);
    int  t = 0;
    logic acc;
    drv(p, 1'b0, 1'b1, a, bc, 64'h0);
    while (1) begin
      @(negedge clk);
      acc = (p == 0) ? !m0_busy : !m1_busy;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 300) begin
        timeout_fail("master_read");
        break;
      end
    end
    drv(p, 1'b0, 1'b0, 29'h0, 8'h0, 64'h0);
  endtask

  task automatic wait_beats(input int n, input string name);
    int k = 0;
    while (n_beats < n && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (n_beats < n) timeout_fail(name);
  endtask

  task automatic pulse_ready(input logic [63:0] d);
    @(posedge clk);
    #1;
    DDRAM_DOUT = d;
    DDRAM_DOUT_READY = 1'b1;
    @(posedge clk);
    #1;
    DDRAM_DOUT_READY = 1'b0;
  endtask

  // Monitor: every accepted memory transaction or returned read beat is popped and compared.
  always @(negedge clk) begin
    if (reset_n) begin
      if (DDRAM_WE && !DDRAM_BUSY) begin
        if (wq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL wr_unexpected: got beat at addr 0x%0h, want none", DDRAM_ADDR);
        end else begin
          mw = wq.pop_front();
          check("wr_addr", 64'(DDRAM_ADDR), 64'(mw.addr));
          check("wr_data", DDRAM_DIN, mw.data);
          check("wr_bcnt", 64'(DDRAM_BURSTCNT), 64'(mw.bc));
          check("wr_busy", 64'({m1_busy, m0_busy}), (mw.port == 1) ? 64'h1 : 64'h2);
          last_cyc[mw.port] = cyc;
        end
        n_beats++;
      end
      if (DDRAM_RD && !DDRAM_BUSY) begin
        if (cq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_cmd_unexpected: got read at addr 0x%0h, want none", DDRAM_ADDR);
        end else begin
          mc = cq.pop_front();
          check("rd_cmd_addr", 64'(DDRAM_ADDR), 64'(mc.addr));
          check("rd_cmd_bcnt", 64'(DDRAM_BURSTCNT), 64'(mc.bc));
        end
      end
      if (m0_dout_ready || m1_dout_ready) begin
        if (rq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_beat_unexpected: got ready {m1,m0}=%b, want none",
                   {m1_dout_ready, m0_dout_ready});
        end else begin
          mr = rq.pop_front();
          check("rd_port", 64'({m1_dout_ready, m0_dout_ready}), (mr.port == 1) ? 64'h2 : 64'h1);
          check("rd_dout0", m0_dout, mr.data);
          check("rd_dout1", m1_dout, mr.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    drv(0, 1'b0, 1'b0, 29'h0, 8'h0, 64'h0);
    drv(1, 1'b0, 1'b0, 29'h0, 8'h0, 64'h0);
    DDRAM_BUSY = 1'b0;
    DDRAM_DOUT = 64'h0;
    DDRAM_DOUT_READY = 1'b0;
    last_cyc[0] = 0;
    last_cyc[1] = 0;
    rdn = 0;

    #12;
    check("rst_we", 64'(DDRAM_WE), 64'h0);
    check("rst_rd", 64'(DDRAM_RD), 64'h0);
    check("rst_busy", 64'({m1_busy, m0_busy}), 64'h3);
    check("rst_rdy", 64'({m1_dout_ready, m0_dout_ready}), 64'h0);
    check("rst_addr", 64'(DDRAM_ADDR), 64'h0);
    check("rst_bcnt", 64'(DDRAM_BURSTCNT), 64'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Stray read-data strobe while idle must not reach either port.
    DDRAM_DOUT = 64'hdead_beef_0000_0001;
    DDRAM_DOUT_READY = 1'b1;
    #2;
    check("idle_stray_rdy", 64'({m1_dout_ready, m0_dout_ready}), 64'h0);
    @(posedge clk);
    #1;
    DDRAM_DOUT_READY = 1'b0;

    // Port 0 write burst of 4.
    for (int i = 0; i < 4; i++) exp_wr(0, 29'h100, 8'd4, i);
    master_write(0, 29'h100, 8'd4, 4);
    @(negedge clk);
    check("t1_idle_we", 64'(DDRAM_WE), 64'h0);
    check("t1_idle_busy", 64'({m1_busy, m0_busy}), 64'h3);
    check("t1_drained", 64'(wq.size()), 64'h0);
    @(posedge clk);
    #1;

    // Port 1 read burst of 2 with memory busy for 3 cycles.
    cq.push_back('{port: 1, addr: 29'h200, bc: 8'd2, data: 64'h0});
    rq.push_back('{port: 1, addr: 29'h200, bc: 8'd2, data: 64'h1111_2222_3333_4444});
    rq.push_back('{port: 1, addr: 29'h200, bc: 8'd2, data: 64'h5555_6666_7777_8888});
    DDRAM_BUSY = 1'b1;
    rdn = 0;
    fork
      master_read(1, 29'h200, 8'd2);
      begin
        for (int k = 0; k < 50 && rdn < 3; k++) begin
          @(negedge clk);
          if (DDRAM_RD) rdn++;
        end
        @(posedge clk);
        #1;
        DDRAM_BUSY = 1'b0;
        @(negedge clk);
        if (DDRAM_RD) rdn++;
        check("t2_rd_cycles", 64'(rdn), 64'd4);
        @(negedge clk);
        check("t2_rd_dropped", 64'(DDRAM_RD), 64'h0);
        check("t2_busy_after", 64'({m1_busy, m0_busy}), 64'h3);
        pulse_ready(64'h1111_2222_3333_4444);
        pulse_ready(64'h5555_6666_7777_8888);
      end
    join
    @(negedge clk);
    check("t2_drained", 64'(rq.size() + cq.size()), 64'h0);
    @(posedge clk);
    #1;

    // Port 1 requests during a port-0 burst of 8 and must wait for it.
    for (int i = 0; i < 8; i++) exp_wr(0, 29'h300, 8'd8, i);
    exp_wr(1, 29'h400, 8'd1, 0);
    fork
      master_write(0, 29'h300, 8'd8, 8);
      begin
        wait_beats(n_beats + 1, "t3_first_beat");
        @(posedge clk);
        #1;
        master_write(1, 29'h400, 8'd1, 1);
      end
    join
    @(negedge clk);
    check("t3_drained", 64'(wq.size()), 64'h0);
    check("t3_gap", 64'(last_cyc[1] - last_cyc[0]), 64'd2);
    @(posedge clk);
    #1;

    // Reset during the second beat of a 4-beat write.
    for (int i = 0; i < 4; i++) exp_wr(0, 29'h500, 8'd4, i);
    fork
      master_write(0, 29'h500, 8'd4, 4);
      begin
        wait_beats(n_beats + 2, "t5_second_beat");
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_we", 64'(DDRAM_WE), 64'h0);
        check("t5_busy", 64'({m1_busy, m0_busy}), 64'h3);
        check("t5_addr", 64'(DDRAM_ADDR), 64'h0);
      end
    join
    wq.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Post-reset port-1 write with burstcnt 0, which behaves as a single beat.
    exp_wr(1, 29'h600, 8'd1, 0);
    master_write(1, 29'h600, 8'd0, 1);
    @(negedge clk);
    check("t6_drained", 64'(wq.size()), 64'h0);
    check("t6_idle_busy", 64'({m1_busy, m0_busy}), 64'h3);
    @(posedge clk);
    #1;

    // Both ports continuously requesting 1-beat writes: 8 x port 0, then port 1 forced.
    for (int i = 0; i < 8; i++) exp_wr(0, 29'h700 + 29'(i), 8'd1, 0);
    exp_wr(1, 29'h800, 8'd1, 0);
    for (int i = 8; i < 16; i++) exp_wr(0, 29'h700 + 29'(i), 8'd1, 0);
    exp_wr(1, 29'h801, 8'd1, 0);
    exp_wr(0, 29'h710, 8'd1, 0);
    fork
      begin
        for (int i = 0; i < 17; i++) master_write(0, 29'h700 + 29'(i), 8'd1, 1);
      end
      begin
        for (int j = 0; j < 2; j++) master_write(1, 29'h800 + 29'(j), 8'd1, 1);
      end
    join
    @(negedge clk);
    check("t4_drained", 64'(wq.size()), 64'h0);

`ifdef DDRAM_ARBITER_STATS_EN
    check("stat_grant0", 64'(stat_grant0), 64'd17);
    check("stat_grant1", 64'(stat_grant1), 64'd3);
    check("stat_forced", 64'(stat_forced), 64'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
